// File: rtl/tmds_pkg.sv
// tmds_pkg: definitions shared by the TMDS transmit encoder and receive decoder.
//   - the four 10-bit control tokens and their {C1,C0} codes
//   - the receive word-alignment FSM state type
//   - token_for(): {C1,C0} -> control token (transmit direction)
package tmds_pkg;

  localparam logic [9:0] TOKEN_C00 = 10'h354;
  localparam logic [9:0] TOKEN_C01 = 10'h0AB;
  localparam logic [9:0] TOKEN_C10 = 10'h154;
  localparam logic [9:0] TOKEN_C11 = 10'h2AB;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_LOCKED = 2'd3
  } align_state_t;

  function automatic logic [9:0] token_for(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = TOKEN_C00;
      2'b01:   t = TOKEN_C01;
      2'b10:   t = TOKEN_C10;
      default: t = TOKEN_C11;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tmds_word_decode.sv
// tmds_word_decode: combinational decode of one 10-bit TMDS word.
// Ports:
//   word      in  10  TMDS word, bit0 first on the wire
//   is_token  out 1   word is one of the four control tokens
//   c         out 2   {C1,C0} of the token (0 for non-tokens)
//   d         out 8   video byte recovered from the word
module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic [9:0] word,
  output logic       is_token,
  output logic [1:0] c,
  output logic [7:0] d
);

  logic [7:0] q;

  always_comb begin
    is_token = 1'b1;
    c        = 2'b00;
    case (word)
      TOKEN_C00: c = 2'b00;
      TOKEN_C01: c = 2'b01;
      TOKEN_C10: c = 2'b10;
      TOKEN_C11: c = 2'b11;
      default:   is_token = 1'b0;
    endcase
  end

  // Undo the optional inversion (bit9), then the XOR/XNOR chain (bit8 selects XOR).
  assign q = word[9] ? ~word[7:0] : word[7:0];
  assign d = {q[7:1] ^ q[6:0] ^ {7{~word[8]}}, q[0]};

endmodule

// File: rtl/tmds_ch_decoder.sv
// tmds_ch_decoder: one TMDS receive channel. Aligns the deserializer word
// boundary using control-token runs (bitslip requests) and decodes the
// aligned words into DE, {C1,C0} and pixel data.
// Ports:
//   sys_clk    in  1   pixel clock
//   sys_rst    in  1   synchronous reset, active-high
//   tmds_word  in  10  deserialized word, bit0 first on the wire
//   bitslip    out 1   one-cycle request to rotate the deserializer word by 1 bit
//   aligned    out 1   high while word alignment is locked
//   slip_cnt   out 4   slips issued since reset, counts 0..9 and wraps
//   vid_de     out 1   data enable
//   vid_c      out 2   {C1,C0}, meaningful while vid_de=0
//   vid_data   out 8   pixel byte, meaningful while vid_de=1
// Latency tmds_word -> vid_*: 2 clocks.
module tmds_ch_decoder
  import tmds_pkg::*;
#(
  parameter int TOKEN_LOCK_CNT = 128,
  parameter int SEARCH_WIN     = 2048,
  parameter int SLIP_SETTLE    = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [9:0] tmds_word,
  output logic       bitslip,
  output logic       aligned,
  output logic [3:0] slip_cnt,
  output logic       vid_de,
  output logic [1:0] vid_c,
  output logic [7:0] vid_data
);

  localparam int RUN_W = $clog2(TOKEN_LOCK_CNT + 1);
  localparam int SET_W = $clog2(SLIP_SETTLE + 1);
  localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(TOKEN_LOCK_CNT);
  localparam logic [11:0]      WIN_LAST = 12'(SEARCH_WIN - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SLIP_SETTLE - 1);

  logic [9:0] word_p1;
  logic       tok_p1;
  logic [1:0] c_p1;
  logic [7:0] d_p1;

  align_state_t     state, state_nxt;
  logic [RUN_W-1:0] run_cnt, run_nxt;
  logic [11:0]      win_cnt, win_nxt;
  logic [SET_W-1:0] set_cnt, set_nxt;
  logic [3:0]       slip_nxt;

  tmds_word_decode u_decode (
    .word     (word_p1),
    .is_token (tok_p1),
    .c        (c_p1),
    .d        (d_p1)
  );

  // ---- stage 1: word register, alignment FSM state and counters ----
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      word_p1  <= '0;
      state    <= ST_SEARCH;
      run_cnt  <= '0;
      win_cnt  <= '0;
      set_cnt  <= '0;
      slip_cnt <= '0;
    end else begin
      word_p1  <= tmds_word;
      state    <= state_nxt;
      run_cnt  <= run_nxt;
      win_cnt  <= win_nxt;
      set_cnt  <= set_nxt;
      slip_cnt <= slip_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    run_nxt   = run_cnt;
    win_nxt   = win_cnt;
    set_nxt   = set_cnt;
    slip_nxt  = slip_cnt;
    case (state)
      ST_SEARCH: begin
        win_nxt = win_cnt + 12'd1;
        if (!tok_p1)
          run_nxt = '0;
        else if (run_cnt != RUN_FULL)
          run_nxt = run_cnt + RUN_W'(1);
        // Lock takes priority over the window expiring on the same cycle.
        if (run_nxt == RUN_FULL) begin
          state_nxt = ST_LOCKED;
          win_nxt   = '0;
        end else if (win_cnt == WIN_LAST) begin
          state_nxt = ST_SLIP;
        end
      end
      ST_SLIP: begin
        slip_nxt  = (slip_cnt == 4'd9) ? 4'd0 : slip_cnt + 4'd1;
        set_nxt   = '0;
        run_nxt   = '0;
        state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        // The deserializer output is unreliable right after a slip; ignore it.
        run_nxt = '0;
        if (set_cnt == SET_LAST) begin
          state_nxt = ST_SEARCH;
          win_nxt   = '0;
        end else begin
          set_nxt = set_cnt + SET_W'(1);
        end
      end
      ST_LOCKED: begin
        if (tok_p1) begin
          win_nxt = '0;
        end else if (win_cnt == WIN_LAST) begin
          // Sync lost: restart the search without slipping, the boundary may still be right.
          state_nxt = ST_SEARCH;
          run_nxt   = '0;
          win_nxt   = '0;
        end else begin
          win_nxt = win_cnt + 12'd1;
        end
      end
      default: state_nxt = ST_SEARCH;
    endcase
  end

  assign bitslip = (state == ST_SLIP);
  assign aligned = (state == ST_LOCKED);

  // ---- stage 2: output registers, gated by the alignment state they appear with ----
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      vid_de   <= 1'b0;
      vid_c    <= 2'b00;
      vid_data <= 8'h00;
    end else if (state_nxt != ST_LOCKED) begin
      vid_de   <= 1'b0;
      vid_c    <= 2'b00;
      vid_data <= 8'h00;
    end else if (tok_p1) begin
      vid_de   <= 1'b0;
      vid_c    <= c_p1;
      vid_data <= 8'h00;
    end else begin
      vid_de   <= 1'b1;
      vid_data <= d_p1;
    end
  end

endmodule

// File: tb/tb_tmds_ch_decoder.sv
module tb_tmds_ch_decoder;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [9:0] tmds_word = 10'h000;
  logic       bitslip;
  logic       aligned;
  logic [3:0] slip_cnt;
  logic       vid_de;
  logic [1:0] vid_c;
  logic [7:0] vid_data;

  tmds_ch_decoder dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .tmds_word (tmds_word),
    .bitslip   (bitslip),
    .aligned   (aligned),
    .slip_cnt  (slip_cnt),
    .vid_de    (vid_de),
    .vid_c     (vid_c),
    .vid_data  (vid_data)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected meaning of a driven word, as the receiver should present it.
  typedef struct packed {
    logic       tok;
    logic [1:0] c;
    logic [7:0] d;
  } exp_t;

  typedef struct {
    logic [9:0] w;
    logic       de;
    logic [1:0] c;
    logic [7:0] d;
  } vec_t;

  exp_t       pipe0, pipe1;
  logic [1:0] model_c;
  logic       model_aligned;
  bit         chk_vid;
  int         cyc;

  function automatic exp_t classify(input logic [9:0] w, input logic [7:0] d);
    exp_t e;
    e.tok = 1'b1;
    e.c   = 2'b00;
    e.d   = 8'h00;
    case (w)
      10'h354: e.c = 2'b00;
      10'h0AB: e.c = 2'b01;
      10'h154: e.c = 2'b10;
      10'h2AB: e.c = 2'b11;
      default: begin
        e.tok = 1'b0;
        e.d   = d;
      end
    endcase
    return e;
  endfunction

  // Transmit-side TMDS data encoding with a free choice of XOR/XNOR and inversion.
  function automatic logic [9:0] enc(input logic [7:0] b, input logic xr, input logic inv);
    logic [7:0] qm;
    qm[0] = b[0];
    for (int i = 1; i < 8; i++)
      qm[i] = xr ? (qm[i-1] ^ b[i]) : ~(qm[i-1] ^ b[i]);
    return {inv, xr, inv ? ~qm : qm};
  endfunction

  function automatic logic [9:0] rot(input logic [9:0] w, input int r);
    logic [19:0] t;
    t = {w, w} >> r;
    return t[9:0];
  endfunction

  // One clock: compare the outputs due now, then drive the next word.
  task automatic step(input logic [9:0] w, input logic [7:0] d_exp);
    logic [12:0] exp_v;
    logic [12:0] act_v;
    @(negedge sys_clk);
    cyc++;
    if (chk_vid) begin
      if (!model_aligned) begin
        exp_v   = '0;
        model_c = 2'b00;
      end else if (pipe1.tok) begin
        exp_v   = {1'b1, 1'b0, 1'b0, pipe1.c, 8'h00};
        model_c = pipe1.c;
      end else begin
        exp_v = {1'b1, 1'b0, 1'b1, model_c, pipe1.d};
      end
      act_v = {aligned, bitslip, vid_de, vid_c, vid_data};
      check($sformatf("vid@%0d {al,slip,de,c,data}", cyc), 32'(act_v), 32'(exp_v));
    end
    pipe1     = pipe0;
    pipe0     = classify(w, d_exp);
    tmds_word = w;
  endtask

  task automatic do_reset(input logic [9:0] w);
    chk_vid = 0;
    sys_rst = 1'b1;
    repeat (3) begin
      @(negedge sys_clk);
      tmds_word = w;
    end
    check("reset_state", 32'({aligned, bitslip, slip_cnt, vid_de, vid_c, vid_data}), 32'd0);
    pipe0         = '0;
    pipe1         = '0;
    model_c       = 2'b00;
    model_aligned = 1'b0;
    cyc           = 0;
    sys_rst       = 1'b0;
  endtask

  task automatic rand_data(output logic [9:0] w, output logic [7:0] b);
    w = 10'h100;
    b = 8'h00;
    for (int t = 0; t < 16; t++) begin
      logic [7:0] bb;
      logic [9:0] ww;
      bb = 8'($urandom_range(0, 255));
      ww = enc(bb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (!classify(ww, bb).tok) begin
        w = ww;
        b = bb;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[11];
    logic [9:0] toks[4];
    logic [9:0] w;
    logic [7:0] b;
    int r, npulse, first, last_p, min_sp, rise;
    bit hit, saw_slip;

    toks[0] = 10'h354; toks[1] = 10'h0AB; toks[2] = 10'h154; toks[3] = 10'h2AB;
    tbl[0]  = '{10'h1FF, 1'b1, 2'b00, 8'h01};
    tbl[1]  = '{10'h100, 1'b1, 2'b00, 8'h00};
    tbl[2]  = '{10'h2AA, 1'b1, 2'b00, 8'h01};
    tbl[3]  = '{10'h0AB, 1'b0, 2'b01, 8'h00};
    tbl[4]  = '{10'h0FF, 1'b1, 2'b01, 8'hFF};
    tbl[5]  = '{10'h154, 1'b0, 2'b10, 8'h00};
    tbl[6]  = '{10'h155, 1'b1, 2'b10, 8'hFF};
    tbl[7]  = '{10'h2AB, 1'b0, 2'b11, 8'h00};
    tbl[8]  = '{10'h1A5, 1'b1, 2'b11, 8'hEF};
    tbl[9]  = '{10'h23C, 1'b1, 2'b11, 8'hBB};
    tbl[10] = '{10'h354, 1'b0, 2'b00, 8'h00};

    // Aligned lock from reset: lock on the 129th cycle after release.
    do_reset(10'h354);
    chk_vid = 1;
    for (int j = 1; j <= 200; j++) begin
      model_aligned = (j >= 129);
      step(10'h354, 8'h00);
      if (j == 128) check("lock_rise_c128", 32'(aligned), 32'd0);
      if (j == 129) check("lock_rise_c129", 32'(aligned), 32'd1);
    end

    // Decode table: data bytes, token codes and C hold across data.
    model_aligned = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i < 11) step(tbl[i].w, tbl[i].d);
      else        step(10'h354, 8'h00);
      if (i >= 2)
        check($sformatf("tbl[%0d] {de,c,data}", i - 2),
              32'({vid_de, vid_c, vid_data}),
              32'({tbl[i-2].de, tbl[i-2].c, tbl[i-2].d}));
    end

    // Random tokens and encoded bytes while locked.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        step(toks[$urandom_range(0, 3)], 8'h00);
      end else begin
        rand_data(w, b);
        step(w, b);
      end
    end

    // Loss of sync after 2048 non-tokens, then relock on tokens.
    step(10'h354, 8'h00);
    for (int k = 1; k <= 2048; k++) begin
      rand_data(w, b);
      step(w, b);
    end
    for (int j = 0; j < 200; j++) begin
      model_aligned = (j == 0) || (j >= 129);
      step(10'h354, 8'h00);
      if (j == 0)   check("sync_held_at_2047", 32'(aligned), 32'd1);
      if (j == 1)   check("sync_lost", 32'(aligned), 32'd0);
      if (j == 128) check("relock_c128", 32'(aligned), 32'd0);
      if (j == 129) check("relock_c129", 32'(aligned), 32'd1);
    end

    // Word boundary off by 3 bits: each bitslip undoes one bit of rotation.
    do_reset(rot(10'h354, 3));
    r = 3; npulse = 0; first = -1; last_p = -1; min_sp = 1 << 30; rise = -1;
    for (int k = 1; k <= 9000; k++) begin
      @(negedge sys_clk);
      if (bitslip) begin
        npulse++;
        if (first < 0) first = k;
        else if (k - last_p < min_sp) min_sp = k - last_p;
        last_p = k;
        if (r > 0) r--;
      end
      if (aligned) begin
        rise = k;
        break;
      end
      tmds_word = rot(10'h354, r);
    end
    check("first_slip_cycle", 32'(first), 32'd2048);
    check("slip_pulses", 32'(npulse), 32'd3);
    check("slip_spacing_ge_2065", 32'(min_sp >= 2065), 32'd1);
    check("lock_after_last_slip", 32'(rise - last_p), 32'd145);
    check("slip_cnt_final", 32'(slip_cnt), 32'd3);

    // slip_cnt wraps after 10 slips; then reset lands in the middle of SETTLE.
    do_reset(10'h000);
    npulse = 0; last_p = -1000; hit = 0;
    for (int k = 1; k <= 23000; k++) begin
      @(negedge sys_clk);
      if (bitslip) begin
        npulse++;
        last_p = k;
      end
      if (npulse > 0 && k == last_p + 1)
        check($sformatf("slip_cnt_after_%0d", npulse), 32'(slip_cnt), 32'(npulse % 10));
      if (npulse == 11 && k == last_p + 5) begin
        hit = 1;
        break;
      end
      tmds_word = 10'h000;
    end
    check("settle_reached", 32'(hit), 32'd1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("rst_mid_settle", 32'({aligned, bitslip, slip_cnt, vid_de, vid_c, vid_data}), 32'd0);
    tmds_word = 10'h354;
    sys_rst   = 1'b0;
    saw_slip  = 0;
    for (int j = 1; j <= 130; j++) begin
      @(negedge sys_clk);
      if (bitslip) saw_slip = 1;
      if (j == 128) check("post_rst_lock_c128", 32'(aligned), 32'd0);
      if (j == 129) check("post_rst_lock_c129", 32'(aligned), 32'd1);
      tmds_word = 10'h354;
    end
    check("post_rst_no_slip", 32'(saw_slip), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
